// File: rtl/demux1_2_fifo.sv
// Registered 1-to-2 word demultiplexer with a small FIFO per output.
// Optional macro DEMUX1_2_STATS_EN enables the contA/contB routed-word counters.
module demux1_2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] entrada,
  input  logic             entradaValid,
  input  logic             controle,
  output logic             entradaReady,
  output logic [WIDTH-1:0] saidaA,
  output logic             saidaAValid,
  input  logic             saidaAReady,
  output logic [WIDTH-1:0] saidaB,
  output logic             saidaBValid,
  input  logic             saidaBReady,
  output logic [CNT_W-1:0] contA,
  output logic [CNT_W-1:0] contB
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic [1:0]       pushSel;
  logic [1:0]       popSel;
  logic [1:0]       fullSel;
  logic [1:0]       validSel;
  logic [1:0]       readySel;
  logic [WIDTH-1:0] headData [2];

  assign readySel = {saidaBReady, saidaAReady};

  // Ready follows the FIFO the current word points at; a full target stalls, never reroutes.
  assign entradaReady = Reset & ~fullSel[controle];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gFifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wrPtrReg;
      logic [PTR_W-1:0] rdPtrReg;
      logic [OCC_W-1:0] occReg;

      assign pushSel[gi]  = entradaValid & entradaReady & (controle == 1'(gi));
      assign validSel[gi] = (occReg != '0);
      assign fullSel[gi]  = (occReg == OCC_W'(DEPTH));
      assign popSel[gi]   = validSel[gi] & readySel[gi];
      assign headData[gi] = validSel[gi] ? mem[rdPtrReg] : '0;

      always_ff @(posedge Clock) begin
        if (pushSel[gi]) begin
          mem[wrPtrReg] <= entrada;
        end
      end

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          wrPtrReg <= '0;
          rdPtrReg <= '0;
          occReg   <= '0;
        end else begin
          if (pushSel[gi]) wrPtrReg <= wrPtrReg + PTR_W'(1);
          if (popSel[gi])  rdPtrReg <= rdPtrReg + PTR_W'(1);
          case ({pushSel[gi], popSel[gi]})
            2'b10:   occReg <= occReg + OCC_W'(1);
            2'b01:   occReg <= occReg - OCC_W'(1);
            default: occReg <= occReg;
          endcase
        end
      end

`ifdef DEMUX1_2_STATS_EN
      logic [CNT_W-1:0] cntReg;
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          cntReg <= '0;
        end else if (pushSel[gi]) begin
          cntReg <= cntReg + CNT_W'(1);
        end
      end
`endif
    end
  endgenerate

  assign saidaA      = headData[0];
  assign saidaAValid = validSel[0];
  assign saidaB      = headData[1];
  assign saidaBValid = validSel[1];

`ifdef DEMUX1_2_STATS_EN
  assign contA = gFifo[0].cntReg;
  assign contB = gFifo[1].cntReg;
`else
  assign contA = '0;
  assign contB = '0;
`endif

endmodule

// File: tb/tb_demux1_2_fifo.sv
// Directed bench for demux1_2_fifo: reset, routing, backpressure, independence,
// asynchronous reset mid-operation and counter wrap (CNT_W=4).
module tb_demux1_2_fifo;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] entrada;
  logic        entradaValid;
  logic        controle;
  logic        entradaReady;
  logic [31:0] saidaA;
  logic        saidaAValid;
  logic        saidaAReady;
  logic [31:0] saidaB;
  logic        saidaBValid;
  logic        saidaBReady;
  logic [3:0]  contA;
  logic [3:0]  contB;

  int checks   = 0;
  int failures = 0;

  demux1_2_fifo #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .entrada(entrada), .entradaValid(entradaValid), .controle(controle),
    .entradaReady(entradaReady),
    .saidaA(saidaA), .saidaAValid(saidaAValid), .saidaAReady(saidaAReady),
    .saidaB(saidaB), .saidaBValid(saidaBValid), .saidaBReady(saidaBReady),
    .contA(contA), .contB(contB)
  );

  always #5 Clock = ~Clock;

  // Expected counter value: the routed-word count when stats are built in, else 0.
  function automatic logic [31:0] cexp(input int n);
`ifdef DEMUX1_2_STATS_EN
    return 32'(n % 16);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b0; entrada = '0; entradaValid = 1'b0; controle = 1'b0;
    saidaAReady = 1'b0; saidaBReady = 1'b0;

    // Reset then idle
    repeat (3) tick();
    chk("ready_in_reset", 32'(entradaReady), 32'd0);
    Reset = 1'b1;
    #1;
    chk("rst_aValid", 32'(saidaAValid), 32'd0);
    chk("rst_bValid", 32'(saidaBValid), 32'd0);
    chk("rst_saidaA", saidaA, 32'd0);
    chk("rst_saidaB", saidaB, 32'd0);
    chk("rst_contA", 32'(contA), 32'd0);
    chk("rst_contB", 32'(contB), 32'd0);
    chk("rst_readyA", 32'(entradaReady), 32'd1);
    controle = 1'b1;
    #1;
    chk("rst_readyB", 32'(entradaReady), 32'd1);
    tick();

    // Single route to A
    controle = 1'b0; entrada = 32'h0000_00A5; entradaValid = 1'b1; saidaAReady = 1'b1;
    tick();
    $display("push A 000000a5");
    entradaValid = 1'b0;
    chk("single_aValid", 32'(saidaAValid), 32'd1);
    chk("single_saidaA", saidaA, 32'h0000_00A5);
    chk("single_bValid", 32'(saidaBValid), 32'd0);
    chk("single_contA", 32'(contA), cexp(1));
    tick();
    chk("single_popped", 32'(saidaAValid), 32'd0);
    chk("single_empty0", saidaA, 32'd0);
    chk("single_contB", 32'(contB), cexp(0));

    // Backpressure and full on B
    saidaBReady = 1'b0; controle = 1'b1; entrada = 32'h1; entradaValid = 1'b1;
    tick();
    $display("push B 00000001");
    chk("bp_head1", saidaB, 32'h1);
    chk("bp_ready1", 32'(entradaReady), 32'd1);
    entrada = 32'h2;
    tick();
    $display("push B 00000002");
    chk("bp_full_ready", 32'(entradaReady), 32'd0);
    entrada = 32'h3;
    tick();
    chk("bp_held_ready", 32'(entradaReady), 32'd0);
    chk("bp_held_head", saidaB, 32'h1);
    chk("bp_held_contB", 32'(contB), cexp(2));
    controle = 1'b0;
    #1;
    chk("bp_A_ready", 32'(entradaReady), 32'd1);
    controle = 1'b1;
    saidaBReady = 1'b1;
    tick();
    chk("bp_out2", saidaB, 32'h2);
    chk("bp_ready_again", 32'(entradaReady), 32'd1);
    tick();
    $display("push B 00000003");
    entradaValid = 1'b0;
    chk("bp_out3", saidaB, 32'h3);
    chk("bp_contB", 32'(contB), cexp(3));
    tick();
    chk("bp_drained", 32'(saidaBValid), 32'd0);

    // Independence: A full, B still accepts
    saidaAReady = 1'b0; saidaBReady = 1'b0; controle = 1'b0; entradaValid = 1'b1;
    entrada = 32'h11;
    tick();
    entrada = 32'h22;
    tick();
    $display("push A 00000011, 00000022");
    chk("ind_A_full", 32'(entradaReady), 32'd0);
    controle = 1'b1; entrada = 32'hDEAD_BEEF; saidaBReady = 1'b1;
    #1;
    chk("ind_B_ready", 32'(entradaReady), 32'd1);
    tick();
    $display("push B deadbeef");
    entradaValid = 1'b0;
    chk("ind_saidaB", saidaB, 32'hDEAD_BEEF);
    chk("ind_A_head", saidaA, 32'h11);
    chk("ind_contA", 32'(contA), cexp(3));
    chk("ind_contB", 32'(contB), cexp(4));
    tick();
    chk("ind_B_drained", 32'(saidaBValid), 32'd0);
    chk("ind_A_kept", 32'(saidaAValid), 32'd1);

    // Mid-operation reset with A holding two words
    #2;
    Reset = 1'b0;
    #1;
    $display("async reset asserted");
    chk("mid_aValid", 32'(saidaAValid), 32'd0);
    chk("mid_saidaA", saidaA, 32'd0);
    chk("mid_ready", 32'(entradaReady), 32'd0);
    chk("mid_contA", 32'(contA), 32'd0);
    #1;
    Reset = 1'b1;
    saidaAReady = 1'b1; controle = 1'b0;
    tick();
    chk("mid_stay_empty", 32'(saidaAValid), 32'd0);
    entrada = 32'h33; entradaValid = 1'b1;
    tick();
    $display("push A 00000033");
    entradaValid = 1'b0;
    chk("mid_new_word", saidaA, 32'h33);
    tick();
    chk("mid_no_ghost", 32'(saidaAValid), 32'd0);

    // Counter wrap: fresh reset, then 17 streamed words to A
    #2;
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    controle = 1'b0; saidaAReady = 1'b1; entradaValid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      entrada = 32'h100 + 32'(i);
      tick();
      $display("push A %h", entrada);
      if (i == 14) chk("wrap_cont15", 32'(contA), cexp(15));
    end
    entradaValid = 1'b0;
    chk("wrap_head", saidaA, 32'h110);
    chk("wrap_contA", 32'(contA), cexp(17));
    chk("wrap_contB", 32'(contB), cexp(0));
    tick();
    chk("wrap_drained", 32'(saidaAValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1_2_fifo.md
Name: demux1_2_fifo

Overview:
- Registered 1-to-2 demultiplexer: the distribution-side counterpart of the 2:1 word mux.
- Accepts a stream of WIDTH-bit words on one valid/ready input.
- Steers each word to output A (controle=0) or output B (controle=1).
- Each output is buffered by its own small FIFO, so one stalled consumer never corrupts the other's data or ordering.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 2, entries per output FIFO; power of two, >= 2
CNT_W, 16, width of per-output routed-word counters

Ports:
Clock  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
entrada  input  WIDTH  input data word
entradaValid  input  1  input word present
controle  input  1  destination select, sampled with the word: 0 = A, 1 = B
entradaReady  output  1  block can accept the word now
saidaA  output  WIDTH  head word of FIFO A
saidaAValid  output  1  FIFO A not empty
saidaAReady  input  1  consumer A takes the head word
saidaB  output  WIDTH  head word of FIFO B
saidaBValid  output  1  FIFO B not empty
saidaBReady  input  1  consumer B takes the head word
contA  output  CNT_W  words written into FIFO A since reset
contB  output  CNT_W  words written into FIFO B since reset

Behaviour:
- Reset (Reset=0, asynchronous): clears all FIFO pointers and occupancy counts. Forces saidaAValid=0, saidaBValid=0, saidaA=0, saidaB=0, contA=0, contB=0.
- Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge.
- entradaReady is combinational: it equals NOT full of the FIFO selected by the current controle.
  - It is independent of entradaValid.
  - It is low while Reset=0.
- Push: when entradaValid=1 and entradaReady=1 at a rising edge, entrada is written to the tail of the selected FIFO and that FIFO's counter increments.
- Pop: when saidaXValid=1 and saidaXReady=1 at a rising edge, the head of FIFO X is removed.
  - saidaXReady while saidaXValid=0 has no effect.
- Latency: a word pushed at edge N is visible on saidaX with saidaXValid=1 after edge N, at the earliest one cycle after acceptance. There is no combinational input-to-output path.
- saidaX is the head entry while valid, and 0 while empty.
- Ordering is preserved per output; there is no ordering relation between A and B.
- Push to FIFO A and pop from FIFO B in the same cycle: both occur.
- Push and pop on the same FIFO in the same cycle: both occur and occupancy is unchanged.
  - Legal only when that FIFO is not full; a full FIFO refuses the push because entradaReady=0, even if a pop happens in the same cycle.
- Full at DEPTH entries; empty at 0.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a count of log2(DEPTH)+1 bits, so full and empty are never ambiguous.
- contA/contB increment by 1 per accepted push and wrap from 2^CNT_W-1 to 0 without a flag.
- An input word whose controle points at a full FIFO is stalled, not rerouted.
  - The upstream must hold entrada and controle stable while entradaValid=1 and entradaReady=0.

Optional Feature:
- Macro DEMUX1_2_STATS_EN.
- Defined: contA/contB counters are instantiated and behave as described above.
- Undefined: counter registers are omitted, and contA and contB are driven constant 0. Ports remain present, so instantiations are unchanged.

Test Plan:
- Reset then idle: hold Reset=0 for 3 cycles and release. Required: saidaAValid=saidaBValid=0, saidaA=saidaB=0, contA=contB=0, and entradaReady=1 for both controle values.
- Single route: push 32'h0000_00A5 with controle=0 while saidaAReady=1. Required: saidaA=32'h0000_00A5 with saidaAValid=1 in the following cycle, popped one cycle later; saidaBValid stays 0; contA=1, contB=0.
- Backpressure and full: hold saidaBReady=0 and push 32'h1, 32'h2, 32'h3 with controle=1.
  - Required: first two accepted, then entradaReady=0 with the third held.
  - Raising saidaBReady yields 1, 2, 3 in order; contB=3.
- Independence: fill A (saidaAReady=0), then push 32'hDEAD_BEEF with controle=1 and saidaBReady=1. Required: accepted immediately, saidaB=32'hDEAD_BEEF; FIFO A contents unchanged.
- Mid-operation reset: with A holding 2 words, pulse Reset low for 2 ns between edges. Required: saidaAValid=0 immediately, and old words never reappear after release.
- Counter wrap: with CNT_W=4, push 17 words to A. Required: contA=1. With DEMUX1_2_STATS_EN undefined, contA stays 0 throughout.
